// File: rtl/row_word_packer.sv
// Repacks assembled rows into memory-width words. Each value gets a little-endian size header.
// The last word of a value is zero-padded and flagged last.
//
// state    | meaning
// ST_HDR   | idle between values; next accepted row is the first of a value
// ST_BODY  | mid-value; rows are appended at byte offset fill
// ST_FLUSH | value complete; drain remaining bytes, final word flagged last
module row_word_packer #(
    parameter int MEMORY_WIDTH        = 512,
    parameter int COL_COUNT           = 3,
    parameter int COL_WIDTH           = 64,
    parameter int VALUE_SIZE_BYTES_NO = 2
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [8*VALUE_SIZE_BYTES_NO-1:0]   in_value_size,
    input  logic [COL_COUNT*COL_WIDTH-1:0]     in_data,
    input  logic                               in_valid,
    input  logic                               in_last,
    output logic                               in_ready,
    output logic [MEMORY_WIDTH-1:0]            out_data,
    output logic                               out_valid,
    output logic                               out_last,
    input  logic                               out_ready
);
    localparam int ROW_W     = COL_COUNT * COL_WIDTH;
    localparam int HDR_W     = 8 * VALUE_SIZE_BYTES_NO;
    localparam int ROW_BYTES = ROW_W / 8;
    localparam int MEM_BYTES = MEMORY_WIDTH / 8;
    localparam int ACC_W     = MEMORY_WIDTH + ROW_W;
    localparam int FILL_W    = $clog2(MEM_BYTES + ROW_BYTES + 1);

    localparam logic [FILL_W-1:0] MEM_BYTES_F = FILL_W'(MEM_BYTES);
    localparam logic [FILL_W-1:0] ROW_BYTES_F = FILL_W'(ROW_BYTES);
    localparam logic [FILL_W-1:0] HDR_BYTES_F = FILL_W'(VALUE_SIZE_BYTES_NO);

    localparam logic [1:0] ST_HDR   = 2'd0;
    localparam logic [1:0] ST_BODY  = 2'd1;
    localparam logic [1:0] ST_FLUSH = 2'd2;

    logic [1:0]        state;
    logic [FILL_W-1:0] fill;
    logic [ACC_W-1:0]  acc;

    logic              in_fire;
    logic              out_fire;
    logic [ACC_W-1:0]  hdr_load;
    logic [ACC_W-1:0]  row_ext;
    logic [ACC_W-1:0]  row_placed;
    logic [FILL_W-1:0] drain;

    assign in_ready  = (state != ST_FLUSH) && (fill < MEM_BYTES_F);
    assign out_valid = (fill >= MEM_BYTES_F) || ((state == ST_FLUSH) && (fill != '0));
    assign out_last  = (state == ST_FLUSH) && (fill <= MEM_BYTES_F);
    // Bytes above fill are always zero in acc, so no output masking is needed.
    assign out_data  = acc[MEMORY_WIDTH-1:0];

    assign in_fire  = in_valid && in_ready;
    assign out_fire = out_valid && out_ready;

    always_comb begin
        hdr_load = '0;
        hdr_load[HDR_W+ROW_W-1:0] = {in_data, in_value_size};
        row_ext = '0;
        row_ext[ROW_W-1:0] = in_data;
        row_placed = row_ext << {fill, 3'b000};
        drain = (fill >= MEM_BYTES_F) ? MEM_BYTES_F : fill;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_HDR;
            fill  <= '0;
            acc   <= '0;
        end else if (in_fire) begin
            if (state == ST_HDR) begin
                acc  <= hdr_load;
                fill <= HDR_BYTES_F + ROW_BYTES_F;
            end else begin
                acc  <= acc | row_placed;
                fill <= fill + ROW_BYTES_F;
            end
            state <= in_last ? ST_FLUSH : ST_BODY;
        end else if (out_fire) begin
            acc  <= acc >> MEMORY_WIDTH;
            fill <= fill - drain;
            if (out_last) begin
                state <= ST_HDR;
            end
        end
    end

endmodule

// File: tb/tb_row_word_packer.sv
// Self-checking bench for row_word_packer: default config plus an exact-fit config instance.
// Table-driven values, then hand-written latency, backpressure, reset and random-stream sequences.
module tb_row_word_packer;
    localparam int MW    = 512;
    localparam int MB    = MW / 8;
    localparam int RB    = 24;
    localparam int ROW_W = 192;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst;
    logic [15:0]      in_value_size;
    logic [ROW_W-1:0] in_data;
    logic             in_valid;
    logic             in_last;
    logic             in_ready;
    logic [MW-1:0]    out_data;
    logic             out_valid;
    logic             out_last;
    logic             out_ready = 1'b1;

    logic [63:0]  f_in_value_size;
    logic [63:0]  f_in_data;
    logic         f_in_valid;
    logic         f_in_last;
    logic         f_in_ready;
    logic [127:0] f_out_data;
    logic         f_out_valid;
    logic         f_out_last;
    logic         f_out_ready = 1'b1;

    row_word_packer u_dut (
        .clk(clk), .rst(rst),
        .in_value_size(in_value_size), .in_data(in_data), .in_valid(in_valid),
        .in_last(in_last), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_last(out_last), .out_ready(out_ready)
    );

    row_word_packer #(
        .MEMORY_WIDTH(128), .COL_COUNT(1), .COL_WIDTH(64), .VALUE_SIZE_BYTES_NO(8)
    ) u_fit (
        .clk(clk), .rst(rst),
        .in_value_size(f_in_value_size), .in_data(f_in_data), .in_valid(f_in_valid),
        .in_last(f_in_last), .in_ready(f_in_ready),
        .out_data(f_out_data), .out_valid(f_out_valid), .out_last(f_out_last), .out_ready(f_out_ready)
    );

    int checks = 0;
    int failures = 0;

    // 0: always ready, 1: random ready, 2: stalled
    int rdy_mode = 0;
    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            1:       out_ready = 1'($urandom_range(0, 1));
            2:       out_ready = 1'b0;
            default: out_ready = 1'b1;
        endcase
    end

    logic [MW-1:0]  act_data[$];
    logic           act_last[$];
    logic [127:0]   fit_data[$];
    logic           fit_last[$];
    int             stab_err = 0;
    logic           have_prev = 1'b0;
    logic [MW-1:0]  prev_data;
    logic           prev_last;

    always @(negedge clk) begin
        if (!rst) begin
            have_prev <= 1'b0;
        end else begin
            if (have_prev && (!out_valid || out_data !== prev_data || out_last !== prev_last))
                stab_err <= stab_err + 1;
            have_prev <= out_valid && !out_ready;
            prev_data <= out_data;
            prev_last <= out_last;
            if (out_valid && out_ready) begin
                act_data.push_back(out_data);
                act_last.push_back(out_last);
            end
        end
    end

    always @(negedge clk) begin
        if (rst && f_out_valid && f_out_ready) begin
            fit_data.push_back(f_out_data);
            fit_last.push_back(f_out_last);
        end
    end

    logic [MW-1:0] exp_data[$];
    logic          exp_last[$];

    task automatic chk_bit(input string name, input logic a, input logic e);
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL %s got=%b want=%b", name, a, e);
        end
    endtask

    task automatic chk_int(input string name, input int a, input int e);
        checks++;
        if (a != e) begin
            failures++;
            $display("FAIL %s got=%0d want=%0d", name, a, e);
        end
    endtask

    task automatic chk_word(input string name, input logic [MW-1:0] a, input logic [MW-1:0] e);
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL %s got=%h want=%h", name, a, e);
        end
    endtask

    task automatic chk_fit(input string name, input logic [127:0] a, input logic [127:0] e);
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL %s got=%h want=%h", name, a, e);
        end
    endtask

    function automatic logic [7:0] rbyte(input logic [7:0] base, input int r, input int j);
        return base + 8'(r * RB + j);
    endfunction

    function automatic logic [ROW_W-1:0] mk_row(input logic [7:0] base, input int r);
        logic [ROW_W-1:0] d;
        for (int j = 0; j < RB; j++) d[8*j +: 8] = rbyte(base, r, j);
        return d;
    endfunction

    // Reference model: flat byte stream of header then rows, cut into zero-padded words.
    task automatic push_exp(input logic [15:0] size, input int nrows, input logic [7:0] base);
        logic [7:0]    bq[$];
        logic [MW-1:0] w;
        int            nw;
        bq.push_back(size[7:0]);
        bq.push_back(size[15:8]);
        for (int r = 0; r < nrows; r++)
            for (int j = 0; j < RB; j++) bq.push_back(rbyte(base, r, j));
        nw = (bq.size() + MB - 1) / MB;
        for (int k = 0; k < nw; k++) begin
            w = '0;
            for (int b = 0; b < MB; b++)
                if (k * MB + b < bq.size()) w[8*b +: 8] = bq[k*MB + b];
            exp_data.push_back(w);
            exp_last.push_back(k == nw - 1);
        end
    endtask

    task automatic send_row(input logic [ROW_W-1:0] d, input logic [15:0] size, input logic last);
        int guard = 0;
        bit took = 0;
        in_data = d;
        in_value_size = size;
        in_last = last;
        in_valid = 1'b1;
        while (!took && guard < 500) begin
            @(negedge clk);
            took = in_ready;
            @(posedge clk);
            #1;
            guard++;
        end
        in_valid = 1'b0;
        in_last = 1'b0;
        if (!took) begin
            checks++;
            failures++;
            $display("FAIL row_accept_timeout got=no_accept want=accept");
        end
    endtask

    task automatic send_value(input logic [15:0] size, input int nrows, input logic [7:0] base,
                              input bit gaps);
        for (int r = 0; r < nrows; r++) begin
            if (gaps) begin
                repeat ($urandom_range(0, 2)) begin
                    in_data = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
                    in_value_size = 16'($urandom());
                    @(posedge clk);
                    #1;
                end
            end
            send_row(mk_row(base, r), (r == 0) ? size : 16'($urandom()), r == nrows - 1);
        end
    endtask

    task automatic send_fit_row(input logic [63:0] d, input logic [63:0] size, input logic last);
        int guard = 0;
        bit took = 0;
        f_in_data = d;
        f_in_value_size = size;
        f_in_last = last;
        f_in_valid = 1'b1;
        while (!took && guard < 100) begin
            @(negedge clk);
            took = f_in_ready;
            @(posedge clk);
            #1;
            guard++;
        end
        f_in_valid = 1'b0;
        f_in_last = 1'b0;
        if (!took) begin
            checks++;
            failures++;
            $display("FAIL fit_accept_timeout got=no_accept want=accept");
        end
    endtask

    task automatic wait_words(input int n, input int limit);
        int g = 0;
        while (act_data.size() < n && g < limit) begin
            @(posedge clk);
            #1;
            g++;
        end
    endtask

    task automatic compare_new(input string tag, input int base_idx);
        int n_act;
        n_act = act_data.size() - base_idx;
        chk_int({tag, "_count"}, n_act, exp_data.size());
        for (int i = 0; i < exp_data.size() && i < n_act; i++) begin
            chk_word({tag, "_data"}, act_data[base_idx + i], exp_data[i]);
            chk_bit({tag, "_last"}, act_last[base_idx + i], exp_last[i]);
        end
    endtask

    typedef struct {
        logic [15:0] size;
        int          nrows;
        logic [7:0]  base;
        int          exp_words;
    } vec_t;

    vec_t tbl[7];

    initial begin
        int bi;
        int nlast;
        int fbi;
        logic [MW-1:0] held_d;
        logic          held_l;

        tbl[0] = '{16'h0048, 3,  8'h10, 2};
        tbl[1] = '{16'h0018, 1,  8'hA0, 1};
        tbl[2] = '{16'h0030, 2,  8'h33, 1};
        tbl[3] = '{16'h1234, 5,  8'h01, 2};
        tbl[4] = '{16'hBEEF, 6,  8'h80, 3};
        tbl[5] = '{16'h00C0, 8,  8'hF0, 4};
        tbl[6] = '{16'h0000, 10, 8'h55, 4};

        rst = 1'b0;
        in_valid = 1'b0;
        in_last = 1'b0;
        in_data = '0;
        in_value_size = '0;
        f_in_valid = 1'b0;
        f_in_last = 1'b0;
        f_in_data = '0;
        f_in_value_size = '0;

        repeat (3) @(posedge clk);
        #1;
        chk_bit("rst_out_valid", out_valid, 1'b0);
        chk_bit("rst_out_last", out_last, 1'b0);
        chk_word("rst_out_data", out_data, '0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk_bit("rst_in_ready", in_ready, 1'b1);

        for (int t = 0; t < 7; t++) begin
            exp_data.delete();
            exp_last.delete();
            bi = act_data.size();
            push_exp(tbl[t].size, tbl[t].nrows, tbl[t].base);
            send_value(tbl[t].size, tbl[t].nrows, tbl[t].base, 1'b0);
            wait_words(bi + tbl[t].exp_words, 300);
            repeat (5) @(posedge clk);
            #1;
            chk_int("tbl_words", act_data.size() - bi, tbl[t].exp_words);
            compare_new("tbl", bi);
            if (t == 0 && act_data.size() >= bi + 2) begin
                chk_word("t0_hdr", {496'd0, act_data[bi][15:0]}, {496'd0, 16'h0048});
                chk_word("t0_row0", {504'd0, act_data[bi][23:16]}, {504'd0, 8'h10});
                chk_word("t0_w1_first", {504'd0, act_data[bi+1][7:0]}, {504'd0, 8'h4E});
                chk_word("t0_w1_pad", act_data[bi+1] >> 80, '0);
            end
        end

        // Latency and zero-bubble return to HDR
        exp_data.delete();
        exp_last.delete();
        bi = act_data.size();
        push_exp(16'h0018, 1, 8'h60);
        send_value(16'h0018, 1, 8'h60, 1'b0);
        @(negedge clk);
        chk_bit("lat_out_valid", out_valid, 1'b1);
        chk_bit("lat_out_last", out_last, 1'b1);
        chk_bit("lat_in_ready", in_ready, 1'b0);
        @(negedge clk);
        chk_bit("bubble_in_ready", in_ready, 1'b1);
        chk_bit("bubble_out_valid", out_valid, 1'b0);
        @(posedge clk);
        #1;
        compare_new("lat", bi);

        // Backpressure: word pending, sink stalled for 5 cycles
        rdy_mode = 2;
        repeat (2) @(posedge clk);
        #1;
        exp_data.delete();
        exp_last.delete();
        bi = act_data.size();
        push_exp(16'h0018, 1, 8'h70);
        send_value(16'h0018, 1, 8'h70, 1'b0);
        @(negedge clk);
        chk_bit("bp_valid0", out_valid, 1'b1);
        held_d = out_data;
        held_l = out_last;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk_bit("bp_valid", out_valid, 1'b1);
            chk_word("bp_data", out_data, held_d);
            chk_bit("bp_last", out_last, held_l);
            chk_bit("bp_in_ready", in_ready, 1'b0);
            chk_int("bp_count", act_data.size() - bi, 0);
        end
        rdy_mode = 0;
        wait_words(bi + 1, 50);
        repeat (4) @(posedge clk);
        #1;
        compare_new("bp", bi);

        // Reset mid-value while a word is pending
        rdy_mode = 2;
        repeat (2) @(posedge clk);
        #1;
        bi = act_data.size();
        for (int r = 0; r < 3; r++) send_row(mk_row(8'h90, r), 16'h0050, 1'b0);
        @(negedge clk);
        chk_bit("mid_out_valid", out_valid, 1'b1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk_bit("mid_rst_valid", out_valid, 1'b0);
        chk_bit("mid_rst_last", out_last, 1'b0);
        chk_word("mid_rst_data", out_data, '0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        rdy_mode = 0;
        exp_data.delete();
        exp_last.delete();
        push_exp(16'h0018, 1, 8'hC0);
        send_value(16'h0018, 1, 8'hC0, 1'b0);
        wait_words(bi + 1, 50);
        repeat (4) @(posedge clk);
        #1;
        compare_new("post_rst", bi);

        // Exact fit: 8-byte header plus one 8-byte row fills a 16-byte word
        fbi = fit_data.size();
        send_fit_row(64'h8877665544332211, 64'h0011223344556677, 1'b1);
        repeat (6) @(posedge clk);
        #1;
        chk_int("fit1_count", fit_data.size() - fbi, 1);
        if (fit_data.size() > fbi) begin
            chk_fit("fit1_data", fit_data[fbi], {64'h8877665544332211, 64'h0011223344556677});
            chk_bit("fit1_last", fit_last[fbi], 1'b1);
        end
        chk_bit("fit1_idle_ready", f_in_ready, 1'b1);
        chk_bit("fit1_idle_valid", f_out_valid, 1'b0);

        fbi = fit_data.size();
        send_fit_row(64'hA1A2A3A4A5A6A7A8, 64'h0000000000000010, 1'b0);
        send_fit_row(64'hB1B2B3B4B5B6B7B8, 64'hFFFFFFFFFFFFFFFF, 1'b1);
        repeat (6) @(posedge clk);
        #1;
        chk_int("fit2_count", fit_data.size() - fbi, 2);
        if (fit_data.size() > fbi + 1) begin
            chk_fit("fit2_w0", fit_data[fbi], {64'hA1A2A3A4A5A6A7A8, 64'h0000000000000010});
            chk_bit("fit2_l0", fit_last[fbi], 1'b0);
            chk_fit("fit2_w1", fit_data[fbi+1], {64'h0, 64'hB1B2B3B4B5B6B7B8});
            chk_bit("fit2_l1", fit_last[fbi+1], 1'b1);
        end

        // Back-to-back random stream with random valid gaps and ready
        rdy_mode = 1;
        exp_data.delete();
        exp_last.delete();
        bi = act_data.size();
        for (int v = 0; v < 200; v++) begin
            logic [15:0] sz;
            logic [7:0]  bs;
            int          nr;
            sz = 16'($urandom());
            bs = 8'($urandom());
            nr = $urandom_range(1, 6);
            push_exp(sz, nr, bs);
            send_value(sz, nr, bs, 1'b1);
        end
        wait_words(bi + exp_data.size(), 5000);
        repeat (5) @(posedge clk);
        #1;
        compare_new("rand", bi);
        nlast = 0;
        for (int i = bi; i < act_data.size(); i++) if (act_last[i]) nlast++;
        chk_int("rand_lasts", nlast, 200);

        chk_int("stability", stab_err, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/row_word_packer.md
# row_word_packer

Downstream stage of the column-to-row converter. Consumes assembled rows (COL_COUNT columns of COL_WIDTH bits, with per-value last flag and value size) and repacks them, byte-contiguously, into MEMORY_WIDTH-bit words for the write path. Each value is prefixed with a VALUE_SIZE_BYTES_NO-byte size header. The final word of each value is zero-padded and flagged last.

## Interface
- MEMORY_WIDTH, 512, output word width in bits. Multiple of 8.
- COL_COUNT, 3, columns per row.
- COL_WIDTH, 64, bits per column. Multiple of 8.
- VALUE_SIZE_BYTES_NO, 2, size-header bytes. Constraint: COL_COUNT*COL_WIDTH/8 + VALUE_SIZE_BYTES_NO <= MEMORY_WIDTH/8.
- Derived: ROW_BYTES = COL_COUNT*COL_WIDTH/8, MEM_BYTES = MEMORY_WIDTH/8.

Ports:
- clk  in  1  sole clock.
- rst  in  1  asynchronous, active-low reset.
- in_value_size  in  8*VALUE_SIZE_BYTES_NO  value size. Sampled only on the first row beat of a value.
- in_data  in  COL_COUNT*COL_WIDTH  row. Column 0 occupies the low bits.
- in_valid  in  1  row valid.
- in_last  in  1  final row of the value.
- in_ready  out  1  row accepted when in_valid && in_ready.
- out_data  out  MEMORY_WIDTH  packed word.
- out_valid  out  1  word valid.
- out_last  out  1  final word of the value.
- out_ready  in  1  word consumed when out_valid && out_ready.

## Operation
- Byte order is little-endian throughout. Header byte k goes to word byte k (bits [8k+:8]). Row byte j (in_data[8j+:8]) is appended at the next free byte offset.
- Accumulator: MEMORY_WIDTH+8*ROW_BYTES bits, plus a byte counter `fill` wide enough for MEM_BYTES+ROW_BYTES. Bytes above fill are held at zero.
- State machine:
  - HDR: waiting for the first row of a value. On accept:
    - acc ← {in_data, in_value_size} (header in the low bytes).
    - fill ← VALUE_SIZE_BYTES_NO + ROW_BYTES.
    - Next state is FLUSH if in_last, otherwise BODY.
  - BODY: on accept, place the row at byte offset fill, then fill ← fill + ROW_BYTES. If in_last, go to FLUSH.
  - FLUSH: no input is accepted. Drain words until fill == 0, then go to HDR.
- in_ready = (state != FLUSH) && (fill < MEM_BYTES).
- out_valid = (fill >= MEM_BYTES) || (state == FLUSH && fill > 0).
- out_data = acc low MEM_BYTES bytes. Bytes at offset fill and above read as zero.
- out_last = (state == FLUSH) && (fill <= MEM_BYTES).
- On an output handshake:
  - acc shifts right by MEMORY_WIDTH, zero-filled.
  - fill ← fill − min(fill, MEM_BYTES).
  - If out_last, the state goes to HDR.
- Input and output handshakes are mutually exclusive by construction: in_ready implies fill < MEM_BYTES, which implies no full word is pending outside FLUSH.
- A value of N rows produces ceil((VALUE_SIZE_BYTES_NO + N*ROW_BYTES)/MEM_BYTES) words. Exactly one of them has out_last=1.
- in_value_size is written verbatim. It is not checked against the row count.

## Timing
- Reset (rst low, asynchronous): state=HDR, fill=0, acc=0. So out_valid=0, out_last=0, out_data=0. in_ready=1 from the first clk edge after rst deasserts.
- Reset mid-value discards all partial data. No last word is emitted.
- Latency: a row accepted at edge t is visible in out_data, and can assert out_valid, from edge t (registered accumulator). Its earliest output handshake is at edge t+1.
- Backpressure: while out_valid && !out_ready, out_data, out_last and out_valid must hold stable.
- in_ready is combinational from registered state only. It has no path from in_valid or out_ready.
- Zero-bubble HDR: the first row of the next value may be accepted on the cycle after the last word's handshake.
- Exact-fit case: if fill == MEM_BYTES on entering FLUSH, a single word is emitted with out_last=1, then the state returns to HDR.

## Test plan
- Defaults, one value of 3 rows, size 0x0048: rows accepted fill to 26, 50, 74 bytes. Expect word0 = header 48 00 plus the first 62 row bytes, last=0. Expect word1 = the remaining 10 row bytes plus 54 zero bytes, last=1.
- One-row value, size 0x0018: a single word, bytes 0–1 = 18 00, bytes 2–25 = row, bytes 26–63 = 0, last=1.
- Exact fit with COL_COUNT=1, COL_WIDTH=64, VALUE_SIZE_BYTES_NO=8, MEMORY_WIDTH=128, one row: exactly one 16-byte word, last=1, no padding word.
- Backpressure: hold out_ready=0 for 5 cycles with a word pending. out_data and out_last must stay stable and in_ready must stay 0. Release, then check the word count is unchanged.
- Back-to-back values with random in_valid/out_ready over 200 values: the scoreboard must match byte streams, header placement, and one last per value.
- Assert rst for 1 cycle mid-value while out_valid=1: out_valid drops immediately. The next value packs from header offset 0 with no stale bytes.
